// File: rtl/mem_scan_if.sv
// mem_scan_if: scan control, memory read port, output handshake and status of mem_scan.
interface mem_scan_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic                     start;
    logic [ADDR_W-1:0]        first_addr;
    logic [ADDR_W-1:0]        last_addr;
    logic                     mem_read;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [DATA_W+ADDR_W-1:0] checksum;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, first_addr, last_addr, mem_data, out_ready,
        output mem_read, mem_addr, out_valid, out_data, checksum, busy, done
    );

    modport slave (
        output start, first_addr, last_addr, mem_data, out_ready,
        input  mem_read, mem_addr, out_valid, out_data, checksum, busy, done
    );
endinterface

// File: rtl/mem_scan.sv
// mem_scan: reads a wrapping address range from a fixed-latency memory, hands each word out and signs it.
// Define MEM_SCAN_XOR_EN for an XOR signature instead of the default additive one.
module mem_scan #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    mem_scan_if.master bus
);
    localparam int CW = DATA_W + ADDR_W;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, last;
    logic [1:0]        cnt;
    logic              capture, accept;
    logic              mem_read, out_valid, busy, done;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     checksum;

    assign capture = state == WAIT && cnt == 2'(RD_LAT - 1);
    assign accept  = state == OUT && bus.out_ready;

    always_comb begin
        state_nxt = state == IDLE  ? (bus.start ? ISSUE : IDLE) :
                    state == ISSUE ? WAIT :
                    state == WAIT  ? (capture ? OUT : WAIT) :
                    state == OUT   ? (accept ? (addr == last ? DONE : ISSUE) : OUT) :
                    IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Strobes and status are registered copies of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr      <= '0;
            last      <= '0;
            cnt       <= '0;
            out_data  <= '0;
            checksum  <= '0;
        end else begin
            mem_read  <= state_nxt == ISSUE;
            out_valid <= state_nxt == OUT;
            busy      <= state_nxt != IDLE;
            done      <= state_nxt == DONE;
            cnt       <= state == WAIT ? cnt + 2'd1 : 2'd0;
            if (state == IDLE && bus.start) begin
                addr     <= bus.first_addr;
                last     <= bus.last_addr;
                checksum <= '0;
            end
            if (capture) begin
                out_data <= bus.mem_data;
`ifdef MEM_SCAN_XOR_EN
                checksum <= checksum ^ CW'(bus.mem_data);
`else
                checksum <= checksum + CW'(bus.mem_data);
`endif
            end
            if (accept && addr != last) addr <= addr + 1'b1;
        end
    end

    assign bus.mem_read  = mem_read;
    assign bus.mem_addr  = addr;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.checksum  = checksum;
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule

// File: tb/tb_mem_scan.sv
// tb_mem_scan: directed scans of mem[a]=a with RD_LAT=1, hand-computed words, timing and signatures.
module tb_mem_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_scan_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    mem_scan #(.ADDR_W(4), .DATA_W(4), .RD_LAT(1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Memory model: mem[a]=a, data valid the cycle after the read strobe.
    always_ff @(posedge clk) if (bus.mem_read) bus.mem_data <= bus.mem_addr;

`ifdef MEM_SCAN_XOR_EN
    localparam logic [7:0] CS_FULL = 8'h00, CS_WRAP = 8'h00, CS_ONE = 8'h05, CS_BP = 8'h01, CS_03 = 8'h00, CS_12 = 8'h03;
`else
    localparam logic [7:0] CS_FULL = 8'h78, CS_WRAP = 8'h1E, CS_ONE = 8'h05, CS_BP = 8'h05, CS_03 = 8'h06, CS_12 = 8'h03;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_read"}, 32'(bus.mem_read), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 0);
        chk({tag, "_checksum"}, 32'(bus.checksum), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
    endtask

    task automatic start_scan(input logic [3:0] f, input logic [3:0] l);
        bus.start = 1'b1;
        bus.first_addr = f;
        bus.last_addr = l;
        step();
        bus.start = 1'b0;
        chk("issue_read", 32'(bus.mem_read), 1);
        chk("issue_addr", 32'(bus.mem_addr), 32'(f));
        chk("issue_busy", 32'(bus.busy), 1);
        chk("issue_cs_clr", 32'(bus.checksum), 0);
    endtask

    // Full scan with out_ready high; a stray start with new bounds arrives mid-scan.
    task automatic run_scan(input logic [3:0] f, input logic [3:0] l, input logic [7:0] exp_cs);
        logic [3:0] exp_w;
        int nw, nd, prev, last_issue;
        bit fin;
        exp_w = f; nw = 0; nd = 0; prev = 0; last_issue = 0; fin = 0;
        bus.out_ready = 1'b1;
        start_scan(f, l);
        for (int c = 1; c < 200 && !fin; c++) begin
            if (c == 2) begin
                bus.start = 1'b1;
                bus.first_addr = f + 4'd7;
                bus.last_addr = f + 4'd3;
            end
            if (c == 3) bus.start = 1'b0;
            step();
            if (bus.mem_read) last_issue = c;
            if (bus.out_valid) begin
                chk("word", 32'(bus.out_data), 32'(exp_w));
                if (nw > 0) chk("gap", 32'(c - prev), 3);
                prev = c;
                exp_w = exp_w + 4'd1;
                nw++;
            end
            if (bus.done) begin
                nd++;
                chk("done_lat", 32'(c - last_issue), 3);
                fin = 1;
            end
        end
        if (!fin) chk("timeout", 0, 1);
        chk("nwords", 32'(nw), 32'(4'(l - f)) + 1);
        chk("checksum", 32'(bus.checksum), 32'(exp_cs));
        step();
        chk("done_once", 32'(bus.done), 0);
        chk("busy_after", 32'(bus.busy), 0);
        chk("cs_hold", 32'(bus.checksum), 32'(exp_cs));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.first_addr = '0;
        bus.last_addr = '0;
        bus.out_ready = 1'b1;
        #1;
        chk_reset("rst");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_reset("idle");

        run_scan(4'd0, 4'd15, CS_FULL);
        run_scan(4'd14, 4'd1, CS_WRAP);
        run_scan(4'd5, 4'd5, CS_ONE);
        run_scan(4'd1, 4'd2, CS_12);

        // Backpressure: hold out_ready low for 5 OUT cycles.
        bus.out_ready = 1'b0;
        start_scan(4'd2, 4'd3);
        step();
        step();
        chk("bp_valid0", 32'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_data", 32'(bus.out_data), 2);
            chk("bp_read", 32'(bus.mem_read), 0);
            chk("bp_addr", 32'(bus.mem_addr), 2);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_accept", 32'(bus.out_valid), 0);
        chk("bp_next_read", 32'(bus.mem_read), 1);
        chk("bp_next_addr", 32'(bus.mem_addr), 3);
        step();
        step();
        chk("bp_word2", 32'(bus.out_data), 3);
        step();
        chk("bp_done", 32'(bus.done), 1);
        chk("bp_cs", 32'(bus.checksum), 32'(CS_BP));
        step();

        // Reset during WAIT of the third word.
        begin
            int nr;
            nr = 0;
            bus.out_ready = 1'b1;
            start_scan(4'd0, 4'd15);
            nr = 1;
            for (int c = 0; c < 50 && nr < 3; c++) begin
                step();
                if (bus.mem_read) nr++;
            end
            chk("third_issue", 32'(nr), 3);
            step();
            chk("in_wait", 32'(bus.mem_read | bus.out_valid), 0);
            rst_n = 1'b0;
            #1;
            chk_reset("mid_rst");
            for (int i = 0; i < 2; i++) begin
                step();
                chk("rst_no_done", 32'(bus.done), 0);
            end
            rst_n = 1'b1;
            for (int i = 0; i < 3; i++) begin
                step();
                chk("rst_idle", 32'(bus.busy), 0);
            end
        end
        run_scan(4'd0, 4'd3, CS_03);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
